// File: rtl/wm_cycle_sequencer.sv
// Washing-machine cycle sequencer: WASH, RINSE (one or two passes), SPIN.
// Time is counted in units of TICK_DIV clocks; pause freezes, abort clears.
module wm_cycle_sequencer #(
  parameter int TW       = 5,
  parameter int TOTW     = 8,
  parameter int TICK_DIV = 4,
  parameter int HEAVY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
  input  logic            abort,
  input  logic [TW-1:0]   wash_in,
  input  logic [TW-1:0]   rinse_in,
  input  logic [TW-1:0]   spin_in,
  input  logic [TW-1:0]   cloth_in,
  output logic [2:0]      phase,
  output logic [TW-1:0]   phase_left,
  output logic [TOTW-1:0] total_left,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW  = (TW + 3 > TOTW + 1) ? TW + 3 : TOTW + 1;
  localparam logic [TKW-1:0] TICK_LAST = TKW'(TICK_DIV - 1);
  localparam logic [SW-1:0]  TOT_MAX   = SW'((1 << TOTW) - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WASH  = 3'd1,
    S_RINSE = 3'd2,
    S_SPIN  = 3'd3,
    S_DONE  = 3'd4,
    S_PAUSE = 3'd5
  } state_t;

  state_t          r_state, w_state;
  state_t          r_saved, w_saved;
  logic            r_pass2, w_pass2;
  logic            r_two, w_two;
  logic [TW-1:0]   r_rinse, w_rinse;
  logic [TW-1:0]   r_spin, w_spin;
  logic [TKW-1:0]  r_tick, w_tick;
  logic [TW-1:0]   r_left, w_left;
  logic [TOTW-1:0] r_total, w_total;
  logic            r_done, w_done;
  logic            r_err, w_err;

  logic            w_heavy;
  logic            w_zero;
  logic            w_run;
  logic            w_wrap;
  logic [SW-1:0]   w_sum;

  // Start-time arithmetic: pass count and unclipped cycle total.
  always_comb begin
    w_heavy = (cloth_in >= TW'(HEAVY));
    w_zero  = (wash_in == '0) && (rinse_in == '0) && (spin_in == '0);
    w_sum   = SW'(wash_in) + SW'(spin_in)
            + (w_heavy ? (SW'(rinse_in) << 1) : SW'(rinse_in));
    w_run   = (r_state == S_WASH) || (r_state == S_RINSE)
            || (r_state == S_SPIN);
    w_wrap  = (r_tick == TICK_LAST);
  end

  // Next-state logic: abort, then pause, then start, then tick counting.
  always_comb begin
    w_state = r_state;
    w_saved = r_saved;
    w_pass2 = r_pass2;
    w_two   = r_two;
    w_rinse = r_rinse;
    w_spin  = r_spin;
    w_tick  = r_tick;
    w_left  = r_left;
    w_total = r_total;
    w_done  = 1'b0;
    w_err   = 1'b0;
    if (abort) begin
      w_state = S_IDLE;
      w_saved = S_IDLE;
      w_pass2 = 1'b0;
      w_two   = 1'b0;
      w_rinse = '0;
      w_spin  = '0;
      w_tick  = '0;
      w_left  = '0;
      w_total = '0;
    end else if (w_run && pause) begin
      w_state = S_PAUSE;
      w_saved = r_state;
    end else if (r_state == S_PAUSE) begin
      if (!pause) w_state = r_saved;
    end else if (start && (r_state == S_IDLE || r_state == S_DONE)) begin
      w_tick  = '0;
      w_pass2 = 1'b0;
      if (w_zero) begin
        w_err   = 1'b1;
        w_state = S_IDLE;
        w_two   = 1'b0;
        w_rinse = '0;
        w_spin  = '0;
        w_left  = '0;
        w_total = '0;
      end else begin
        w_two   = w_heavy;
        w_rinse = rinse_in;
        w_spin  = spin_in;
        w_total = (w_sum > TOT_MAX) ? '1 : w_sum[TOTW-1:0];
        if (wash_in != '0) begin
          w_state = S_WASH;
          w_left  = wash_in;
        end else if (rinse_in != '0) begin
          w_state = S_RINSE;
          w_left  = rinse_in;
        end else begin
          w_state = S_SPIN;
          w_left  = spin_in;
        end
      end
    end else if (w_run) begin
      if (!w_wrap) begin
        w_tick = r_tick + 1'b1;
      end else begin
        w_tick  = '0;
        w_total = (r_total != '0) ? r_total - 1'b1 : r_total;
        if (r_left != TW'(1)) begin
          w_left = r_left - 1'b1;
        end else if (r_state == S_WASH && r_rinse != '0) begin
          w_state = S_RINSE;
          w_left  = r_rinse;
          w_pass2 = 1'b0;
        end else if (r_state == S_RINSE && r_two && !r_pass2) begin
          w_left  = r_rinse;
          w_pass2 = 1'b1;
        end else if (r_state != S_SPIN && r_spin != '0) begin
          w_state = S_SPIN;
          w_left  = r_spin;
        end else begin
          w_state = S_DONE;
          w_left  = '0;
          w_total = '0;
          w_done  = 1'b1;
        end
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_saved <= S_IDLE;
      r_pass2 <= 1'b0;
      r_two   <= 1'b0;
      r_rinse <= '0;
      r_spin  <= '0;
      r_tick  <= '0;
      r_left  <= '0;
      r_total <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_saved <= w_saved;
      r_pass2 <= w_pass2;
      r_two   <= w_two;
      r_rinse <= w_rinse;
      r_spin  <= w_spin;
      r_tick  <= w_tick;
      r_left  <= w_left;
      r_total <= w_total;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign phase      = r_state;
  assign phase_left = r_left;
  assign total_left = r_total;
  assign busy       = w_run || (r_state == S_PAUSE);
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_wm_cycle_sequencer.sv
// Bench for wm_cycle_sequencer: directed scenarios then random traffic,
// checked each cycle against a segment-queue model of the wash program.
module tb_wm_cycle_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] wash = '0, rinse = '0, spin = '0, cloth = '0;

  logic [2:0] phA, phB;
  logic [4:0] plA, plB;
  logic [7:0] tlA;
  logic [5:0] tlB;
  logic       busyA, busyB, doneA, doneB, errA, errB;

  int total = 0;
  int bad   = 0;

  wm_cycle_sequencer #(.TW(5), .TOTW(8), .TICK_DIV(TD), .HEAVY(3)) dutA (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .wash_in(wash), .rinse_in(rinse), .spin_in(spin), .cloth_in(cloth),
    .phase(phA), .phase_left(plA), .total_left(tlA),
    .busy(busyA), .done(doneA), .err(errA)
  );

  wm_cycle_sequencer #(.TW(5), .TOTW(6), .TICK_DIV(TD), .HEAVY(3)) dutB (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .wash_in(wash), .rinse_in(rinse), .spin_in(spin), .cloth_in(cloth),
    .phase(phB), .phase_left(plB), .total_left(tlB),
    .busy(busyB), .done(doneB), .err(errB)
  );

  always #5 clk = ~clk;

  // Reference model: remaining program as a queue of (phase, duration).
  int q_ph[$];
  int q_dur[$];
  int m_cyc, m_wraps, m_totA, m_totB;
  bit m_run, m_pause, m_doneS, e_done, e_err;

  function automatic void m_reset();
    q_ph.delete();
    q_dur.delete();
    m_cyc = 0; m_wraps = 0; m_totA = 0; m_totB = 0;
    m_run = 0; m_pause = 0; m_doneS = 0; e_done = 0; e_err = 0;
  endfunction

  function automatic void m_step(bit s, bit p, bit a, bit r);
    int w, ri, sp, np, sum;
    e_done = 0;
    e_err  = 0;
    if (r || a) begin
      m_reset();
    end else if (m_run) begin
      if (m_pause) begin
        if (!p) m_pause = 0;
      end else if (p) begin
        m_pause = 1;
      end else begin
        m_cyc++;
        if (m_cyc % TD == 0) m_wraps++;
        if (m_cyc == q_dur[0] * TD) begin
          void'(q_ph.pop_front());
          void'(q_dur.pop_front());
          m_cyc = 0;
          if (q_ph.size() == 0) begin
            m_run = 0; m_doneS = 1; e_done = 1;
          end
        end
      end
    end else if (s) begin
      w = int'(wash); ri = int'(rinse); sp = int'(spin);
      if (w + ri + sp == 0) begin
        m_doneS = 0;
        e_err   = 1;
      end else begin
        np  = (int'(cloth) >= 3) ? 2 : 1;
        sum = w + ri * np + sp;
        if (w > 0) begin q_ph.push_back(1); q_dur.push_back(w); end
        for (int k = 0; k < np; k++)
          if (ri > 0) begin q_ph.push_back(2); q_dur.push_back(ri); end
        if (sp > 0) begin q_ph.push_back(3); q_dur.push_back(sp); end
        m_totA = (sum > 255) ? 255 : sum;
        m_totB = (sum > 63) ? 63 : sum;
        m_cyc = 0; m_wraps = 0;
        m_run = 1; m_pause = 0; m_doneS = 0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int ep, el, ea, eb;
    ep = m_run ? (m_pause ? 5 : q_ph[0]) : (m_doneS ? 4 : 0);
    el = m_run ? q_dur[0] - m_cyc / TD : 0;
    ea = m_run ? ((m_totA > m_wraps) ? m_totA - m_wraps : 0) : 0;
    eb = m_run ? ((m_totB > m_wraps) ? m_totB - m_wraps : 0) : 0;
    chk("phase", 32'(phA), 32'(ep));
    chk("phase_left", 32'(plA), 32'(el));
    chk("total_left", 32'(tlA), 32'(ea));
    chk("busy", 32'(busyA), 32'(m_run));
    chk("done", 32'(doneA), 32'(e_done));
    chk("err", 32'(errA), 32'(e_err));
    chk("total_left_sat", 32'(tlB), 32'(eb));
    chk("phase_b", 32'(phB), 32'(ep));
  endtask

  task automatic cyc(input bit s, input bit p, input bit a, input bit r);
    start = s; pause = p; abort = a; rst = r;
    @(posedge clk);
    m_step(s, p, a, r);
    #1;
    check_all();
  endtask

  task automatic setd(input int w, input int r, input int s, input int c);
    wash = 5'(w); rinse = 5'(r); spin = 5'(s); cloth = 5'(c);
  endtask

  task automatic run_to_done(input int limit, inout int n);
    bit seen;
    seen = 0;
    for (int k = 0; k < limit && !seen; k++) begin
      cyc(0, 0, 0, 0);
      n++;
      if (doneA === 1'b1) seen = 1;
    end
    chk("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int n;
    bit p;
    m_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("rst_phase", 32'(phA), 32'd0);
    cyc(0, 1, 0, 0);

    setd(2, 1, 1, 2);
    cyc(1, 0, 0, 0);
    chk("tot_035", 32'(tlA), 32'd4);
    n = 0; run_to_done(100, n);
    chk("lat_035", 32'(n), 32'd16);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);

    setd(1, 3, 1, 3);
    cyc(1, 0, 0, 0);
    chk("tot_036", 32'(tlA), 32'd8);
    n = 0; run_to_done(100, n);
    chk("lat_036", 32'(n), 32'd32);

    setd(0, 0, 0, 5);
    cyc(1, 0, 0, 0);
    chk("err_037", 32'(errA), 32'd1);
    chk("idle_037", 32'(phA), 32'd0);
    cyc(0, 0, 0, 0);
    setd(0, 2, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rinse_037", 32'(phA), 32'd2);
    n = 0; run_to_done(100, n);
    chk("lat_037", 32'(n), 32'd8);

    setd(3, 1, 1, 0);
    cyc(1, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 4; k++) begin cyc(0, 0, 0, 0); n++; end
    for (int k = 0; k < 5; k++) begin cyc(1, 1, 0, 0); n++; end
    chk("pause_038", 32'(phA), 32'd5);
    chk("frozen_038", 32'(plA), 32'd2);
    run_to_done(100, n);
    chk("lat_038", 32'(n), 32'd26);

    setd(2, 2, 1, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0);
    chk("in_rinse_039", 32'(phA), 32'd2);
    cyc(1, 0, 1, 0);
    chk("abort_039", 32'(phA), 32'd0);
    chk("abort_tot_039", 32'(tlA), 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0);
    setd(2, 1, 1, 2);
    cyc(1, 0, 0, 0);
    n = 0; run_to_done(100, n);
    chk("lat_039", 32'(n), 32'd16);

    setd(2, 2, 2, 4);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("rst_mid", 32'(phA), 32'd0);
    cyc(0, 0, 0, 0);

    setd(31, 31, 31, 31);
    cyc(1, 0, 0, 0);
    chk("sat_040", 32'(tlB), 32'd63);
    chk("nosat_040", 32'(tlA), 32'd124);
    n = 0; run_to_done(600, n);
    chk("lat_040", 32'(n), 32'd496);

    p = 0;
    for (int k = 0; k < 1500; k++) begin
      bit s, a;
      s = ($urandom % 6 == 0);
      if (s)
        setd($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 5));
      if ($urandom % 20 == 0) p = !p;
      a = ($urandom % 200 == 0);
      cyc(s, p, a, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wm_cycle_sequencer.md
WM_CYCLE_SEQUENCER -- requirements
Module: wm_cycle_sequencer

Interface
REQ-001 Parameter TW, default 5, width of the per-phase time and cloth fields.
REQ-002 Parameter TOTW, default 8, width of the total-remaining-time output.
REQ-003 Parameter TICK_DIV, default 4, clocks per time unit; legal values are 1 or more.
REQ-004 Parameter HEAVY, default 3, cloth threshold (TW bits) for a double rinse.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request a new cycle; sampled each clk.
REQ-008 pause  in  1  level; freezes a running cycle while high.
REQ-009 abort  in  1  cancels any cycle.
REQ-010 wash_in, rinse_in, spin_in  in  TW each  phase durations in time units.
REQ-011 cloth_in  in  TW  load level.
REQ-012 phase  out  3  encoding: 0 IDLE, 1 WASH, 2 RINSE, 3 SPIN, 4 DONE, 5 PAUSE.
REQ-013 phase_left  out  TW  time units left in the current phase.
REQ-014 total_left  out  TOTW  time units left in the whole cycle.
REQ-015 busy  out  1  high in WASH, RINSE, SPIN and PAUSE.
REQ-016 done  out  1  one-cycle pulse on entry to DONE.
REQ-017 err  out  1  one-cycle pulse when a start is rejected.

Function
REQ-018 Start acceptance: start is accepted only in IDLE or DONE, and is ignored while busy.
REQ-019 On acceptance, the block latches all four inputs and computes passes = 2 if cloth_in >= HEAVY, else 1.
REQ-020 total = wash + rinse*passes + spin, computed without overflow and saturated to 2^TOTW-1, then loaded into total_left.
REQ-021 Zero-duration start: if wash, rinse and spin are all 0, start is rejected, err pulses, and phase stays (or returns to) IDLE with all counters 0.
REQ-022 Phase entry timing: the phase entered takes effect on the edge that samples start, and phase_left loads that phase's duration on the same edge.
REQ-023 Phase order: WASH, then RINSE (repeated passes times), then SPIN, then DONE; a phase with duration 0 is skipped and never appears on phase.
REQ-024 Tick counter: counts 0..TICK_DIV-1 only in WASH, RINSE or SPIN, and clears on every phase entry and on every rinse reload.
REQ-025 Tick wrap: each wrap decrements phase_left by 1 and decrements total_left by 1, with total_left saturating at 0.
REQ-026 Phase exit: when a wrap occurs with phase_left = 1, the block enters the next non-skipped phase (or reloads RINSE for pass 2) on that same edge, so a phase of duration D lasts exactly D*TICK_DIV cycles.
REQ-027 DONE state: DONE holds with busy = 0, phase_left = 0 and total_left = 0 until start or abort.
REQ-028 Pause entry: pause high in WASH, RINSE or SPIN enters PAUSE on the next edge, saves the phase and pass, and freezes the tick counter, phase_left and total_left.
REQ-029 Pause exit: pause low in PAUSE restores the saved phase on the next edge, and counting resumes from the frozen values.
REQ-030 Pause outside a running cycle (IDLE or DONE) has no effect.
REQ-031 Abort: abort in any state enters IDLE on the next edge, clears all counters and outputs, and produces no done pulse.
REQ-032 Priority: rst > abort > pause > start; abort and start in the same cycle leave the block in IDLE.

Reset
REQ-033 While rst is high at an edge, phase = IDLE and phase_left, total_left, busy, done, err and the tick counter are all 0, and latched inputs are cleared.
REQ-034 rst mid-cycle discards the cycle with no done pulse; operation resumes in IDLE on the first edge with rst low.

Verification (TICK_DIV = 4 unless stated)
REQ-035 wash=2, rinse=1, spin=1, cloth=2, start -> total_left = 4; WASH for 8 cycles, RINSE 4, SPIN 4; done pulses 16 cycles after start is accepted; total_left = 0.
REQ-036 wash=1, rinse=3, spin=1, cloth=3, start -> passes = 2, total_left = 8; RINSE lasts 24 cycles with phase_left reloading to 3 after 12; done after 32 cycles.
REQ-037 All durations 0, start -> err = 1 for one cycle, phase = 0, busy = 0; next, wash=0, rinse=2, spin=0 -> phase goes straight to 2; done after 8 cycles.
REQ-038 Pause high for 5 cycles mid-WASH -> phase = 5 with phase_left and total_left frozen; phase returns to 1 afterward; done is delayed by exactly 6 cycles (1 entry + 5 held).
REQ-039 Abort mid-RINSE, with start asserted in the same cycle -> phase = 0, total_left = 0 on the next edge; no done pulse; a later start behaves as after reset.
REQ-040 TOTW = 6, wash=31, rinse=31, spin=31, cloth=31, start -> total_left = 63, saturated; total_left holds at 0 once reached, and done still occurs after 124*TICK_DIV cycles.
